// File: rtl/usb2_ep_reader.sv
// usb2_ep_reader
//   Streams one committed packet from the endpoint buffer to the packet
//   transmitter each time the host sends an IN token. The module answers with
//   NAK when the buffer is empty and with a zero-length packet when the
//   committed length is zero. After the host ACKs, it advances the data toggle
//   and releases the buffer through a level arm/ack handshake. A handshake
//   timeout keeps the buffer, so the next IN token resends it.
//
// Ports
//   i_phy_clk, i_reset           clock; asynchronous active-high reset
//   i_token_in                   IN token pulse for this endpoint
//   i_buf_out_hasdata/_len       committed-packet status and length
//   o_buf_out_addr, i_buf_out_q  buffer read port (1-cycle read latency)
//   o_buf_out_arm, i_buf_out_arm_ack  buffer release handshake
//   o_tx_data/_valid/_last, i_tx_ready  byte stream to the transmitter
//   o_tx_zlp, o_tx_nak           one-cycle ZLP / NAK requests
//   i_hs_ack, i_hs_timeout       handshake result from the host
//   o_data_toggle_act            one-cycle data-toggle advance
//   o_busy                       high whenever the FSM is not idle
module usb2_ep_reader #(
    parameter int unsigned MAX_PKT = 512
) (
    input  logic       i_phy_clk,
    input  logic       i_reset,
    input  logic       i_token_in,
    input  logic       i_buf_out_hasdata,
    input  logic [9:0] i_buf_out_len,
    output logic [8:0] o_buf_out_addr,
    input  logic [7:0] i_buf_out_q,
    output logic       o_buf_out_arm,
    input  logic       i_buf_out_arm_ack,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_tx_last,
    output logic       o_tx_zlp,
    output logic       o_tx_nak,
    input  logic       i_hs_ack,
    input  logic       i_hs_timeout,
    output logic       o_data_toggle_act,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_STREAM, S_WAIT_HS, S_ARM, S_ARM_REL
    } state_t;

    localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

    state_t     r_state;
    state_t     w_next;
    logic [9:0] r_cnt;       // address being fetched; one ahead of the byte on tx_data
    logic [9:0] r_len;
    logic       r_hold_vld;  // tx_data comes from r_hold while stalled
    logic [7:0] r_hold;
    logic       r_zlp;
    logic       r_nak;
    logic       r_toggle;

    logic w_tok_nak;
    logic w_tok_zlp;
    logic w_tok_data;
    logic w_accept;
    logic w_last;

    always_comb begin
        w_tok_nak  = (r_state == S_IDLE) && i_token_in && !i_buf_out_hasdata;
        w_tok_zlp  = (r_state == S_IDLE) && i_token_in && i_buf_out_hasdata
                     && (i_buf_out_len == '0);
        w_tok_data = (r_state == S_IDLE) && i_token_in && i_buf_out_hasdata
                     && (i_buf_out_len != '0);
        w_accept   = (r_state == S_STREAM) && i_tx_ready;
        w_last     = (r_cnt == r_len);
    end

    // State register
    always_ff @(posedge i_phy_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tok_zlp)       w_next = S_WAIT_HS;
                else if (w_tok_data) w_next = S_FETCH;
            end
            S_FETCH:   w_next = S_STREAM;
            S_STREAM:  if (w_accept && w_last) w_next = S_WAIT_HS;
            S_WAIT_HS: begin
                if (i_hs_ack)          w_next = S_ARM;
                else if (i_hs_timeout) w_next = S_IDLE;
            end
            S_ARM:     if (i_buf_out_arm_ack)  w_next = S_ARM_REL;
            S_ARM_REL: if (!i_buf_out_arm_ack) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath and registered pulses
    // On a stall the RAM output is parked in r_hold while the address has
    // already moved on; the RAM then delivers the following byte, so the
    // address only advances on acceptance and no byte is lost or repeated.
    always_ff @(posedge i_phy_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
            r_zlp      <= 1'b0;
            r_nak      <= 1'b0;
            r_toggle   <= 1'b0;
        end else begin
            r_nak    <= w_tok_nak;
            r_zlp    <= w_tok_zlp;
            r_toggle <= (r_state == S_WAIT_HS) && i_hs_ack;
            case (r_state)
                S_IDLE: begin
                    if (w_tok_data) begin
                        r_cnt      <= '0;
                        r_len      <= (i_buf_out_len > MAX_LEN) ? MAX_LEN : i_buf_out_len;
                        r_hold_vld <= 1'b0;
                    end
                end
                S_FETCH: r_cnt <= 10'd1;
                S_STREAM: begin
                    if (w_accept) begin
                        r_hold_vld <= 1'b0;
                        r_cnt      <= w_last ? '0 : r_cnt + 10'd1;
                    end else if (!r_hold_vld) begin
                        r_hold_vld <= 1'b1;
                        r_hold     <= i_buf_out_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_buf_out_addr    = r_cnt[8:0];
        o_tx_valid        = (r_state == S_STREAM);
        o_tx_data         = '0;
        if (r_state == S_STREAM) o_tx_data = r_hold_vld ? r_hold : i_buf_out_q;
        o_tx_last         = (r_state == S_STREAM) && w_last;
        o_buf_out_arm     = (r_state == S_ARM);
        o_busy            = (r_state != S_IDLE);
        o_tx_zlp          = r_zlp;
        o_tx_nak          = r_nak;
        o_data_toggle_act = r_toggle;
    end

endmodule
